// File: rtl/x_mem_rv32i.sv
// x_mem_rv32i: single-port RV32I data memory with wait states, GPIO register, cycle counter and preload port
module x_mem_rv32i #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_valid,
  input  logic        i_rnw,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  output logic        o_accept,
  output logic [31:0] o_data,
  input  logic        i_ld_en,
  input  logic [31:0] i_ld_addr,
  input  logic [31:0] i_ld_data,
  output logic [7:0]  o_gpio
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] GPIO_A = 32'hFFFF_FFF0;
  localparam logic [31:0] CNT_A  = 32'hFFFF_FFF4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [31:0] mem [DEPTH];
  logic [31:0] addr_q, data_q, cycles, rd_addr, rd_val;
  logic [3:0]  wcnt;
  logic        rnw_q, rd_rnw, cap, wr, unused_ok;
  assign unused_ok = ^i_ld_addr[1:0];
  assign cap       = state == IDLE && i_valid && !i_ld_en;
  assign o_accept  = state == RESP && i_valid;
  assign wr        = o_accept && !rnw_q;
  assign rd_addr   = state == IDLE ? i_addr : addr_q;
  assign rd_rnw    = state == IDLE ? i_rnw : rnw_q;
  always_comb begin
    rd_val   = rd_addr == GPIO_A ? {24'd0, o_gpio} :
               rd_addr == CNT_A ? cycles :
               rd_addr[31:AW+2] == '0 ? mem[rd_addr[AW+1:2]] : 32'd0;
    state_nx = state == IDLE ? (cap ? ((LATENCY > 0) ? WAIT : RESP) : IDLE) :
               state == WAIT ? (!i_valid ? IDLE : wcnt == 4'd1 ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge i_clk or negedge i_nrst)
    if (!i_nrst) begin
      state  <= IDLE;
      wcnt   <= '0;
      cycles <= '0;
      o_data <= '0;
      o_gpio <= '0;
      addr_q <= '0;
      data_q <= '0;
      rnw_q  <= 1'b1;
    end else begin
      state  <= state_nx;
      cycles <= cycles + 32'd1;
      wcnt   <= cap ? 4'(LATENCY) : state == WAIT ? wcnt - 4'd1 : wcnt;
      if (cap) begin
        addr_q <= i_addr;
        data_q <= i_data;
        rnw_q  <= i_rnw;
      end
      if (state_nx == RESP && rd_rnw) o_data <= rd_val;
      if (wr && addr_q == GPIO_A) o_gpio <= data_q[7:0];
    end
  // loader is written second so it wins a same-word collision with a bus write
  always_ff @(posedge i_clk) begin
    if (wr && addr_q[31:AW+2] == '0) mem[addr_q[AW+1:2]] <= data_q;
    if (i_ld_en && i_ld_addr[31:AW+2] == '0) mem[i_ld_addr[AW+1:2]] <= i_ld_data;
  end
endmodule

// File: tb/tb_x_mem_rv32i.sv
// tb_x_mem_rv32i: scoreboard bench; main DUT at LATENCY=3, second DUT at LATENCY=1 for the preload/read case
module tb_x_mem_rv32i;
  localparam int LAT = 3;
  localparam logic [31:0] GPIO_A = 32'hFFFF_FFF0;
  localparam logic [31:0] CNT_A  = 32'hFFFF_FFF4;
  typedef struct {logic rd; logic [31:0] d; int c;} exp_t;
  logic i_clk = 0, i_nrst = 1, i_valid = 0, i_rnw = 0, i_ld_en = 0, b_valid = 0;
  logic [31:0] i_addr = 0, i_data = 0, i_ld_addr = 0, i_ld_data = 0;
  logic o_accept, b_acc;
  logic [31:0] o_data, b_data, last = 0, d1;
  logic [7:0] o_gpio, b_gpio;
  int cyc = 0, n_chk = 0, n_err = 0, last_c = 0, c1;
  exp_t q[$];
  exp_t e;

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  x_mem_rv32i #(.DEPTH(256), .LATENCY(LAT)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_valid(i_valid), .i_rnw(i_rnw), .i_addr(i_addr),
    .i_data(i_data), .o_accept(o_accept), .o_data(o_data), .i_ld_en(i_ld_en),
    .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data), .o_gpio(o_gpio));

  x_mem_rv32i #(.DEPTH(256), .LATENCY(1)) dut1 (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_valid(b_valid), .i_rnw(1'b1), .i_addr(32'd0),
    .i_data(32'd0), .o_accept(b_acc), .o_data(b_data), .i_ld_en(i_ld_en),
    .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data), .o_gpio(b_gpio));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  always @(negedge i_clk)
    if (i_nrst && o_accept) begin
      if (q.size() == 0) chk("spurious_accept", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("accept_cycle", 32'(cyc), 32'(e.c));
        if (e.rd) chk("read_data", o_data, e.d);
      end
      last   = o_data;
      last_c = cyc;
    end

  task automatic wait_acc();
    int n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_accept && n < 40);
    if (!o_accept) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic xfer(input logic rnw, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] x, input logic ck);
    exp_t s = '{rd: rnw & ck, d: x, c: cyc + 1 + LAT};
    i_valid = 1; i_rnw = rnw; i_addr = a; i_data = d;
    q.push_back(s);
    wait_acc();
    @(posedge i_clk);
    #1 i_valid = 0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    i_ld_en = 1; i_ld_addr = a; i_ld_data = d;
    @(posedge i_clk);
    #1 i_ld_en = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    #2 i_nrst = 0;
    #1;
    chk("rst_accept", 32'(o_accept), 0);
    chk("rst_data", o_data, 0);
    chk("rst_gpio", 32'(o_gpio), 0);
    chk("l1_rst_gpio", 32'(b_gpio), 0);
    @(posedge i_clk);
    #1;
    load(32'h0, 32'h13);
    load(32'h20, 32'h2020_2020);
    load(32'h24, 32'h2424_2424);
    load(32'h400, 32'hBAD0_0400);
    i_nrst = 1; b_valid = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      chk("l1_accept", 32'(b_acc), 32'(k == 2));
    end
    chk("l1_data", b_data, 32'h13);
    @(posedge i_clk);
    #1 b_valid = 0;
    xfer(1'b1, 32'h0, 0, 32'h13, 1'b1);
    xfer(1'b0, 32'h10, 32'hDEAD_BEEF, 0, 1'b0);
    xfer(1'b1, 32'h10, 0, 32'hDEAD_BEEF, 1'b1);
    xfer(1'b0, GPIO_A, 32'h1234_565A, 0, 1'b0);
    chk("gpio_write", 32'(o_gpio), 32'h5A);
    xfer(1'b1, GPIO_A, 0, 32'h5A, 1'b1);
    xfer(1'b1, 32'h20, 0, 32'h2020_2020, 1'b1);
    xfer(1'b1, 32'h24, 0, 32'h2424_2424, 1'b1);
    xfer(1'b1, 32'h13, 0, 32'hDEAD_BEEF, 1'b1);
    xfer(1'b1, 32'h0001_0000, 0, 0, 1'b1);
    xfer(1'b0, 32'h0001_0000, 32'hFFFF_FFFF, 0, 1'b0);
    xfer(1'b0, CNT_A, 32'h5555_5555, 0, 1'b0);
    xfer(1'b1, 32'h0, 0, 32'h13, 1'b1);
    xfer(1'b1, CNT_A, 0, 0, 1'b0);
    d1 = last; c1 = last_c;
    xfer(1'b1, CNT_A, 0, 0, 1'b0);
    chk("cnt_delta", last - d1, 32'(last_c - c1));
    force dut.cycles = 32'hFFFF_FFFF;
    fork
      xfer(1'b1, CNT_A, 0, 0, 1'b1);
      begin
        @(posedge i_clk);
        @(posedge i_clk);
        #1 release dut.cycles;
      end
    join
    fork
      xfer(1'b0, 32'h30, 32'h1111_1111, 0, 1'b0);
      begin
        for (int n = 0; n < 40 && !o_accept; n++) @(negedge i_clk);
        i_ld_en = 1; i_ld_addr = 32'h30; i_ld_data = 32'h2222_2222;
        @(posedge i_clk);
        #1 i_ld_en = 0;
      end
    join
    xfer(1'b1, 32'h30, 0, 32'h2222_2222, 1'b1);
    i_ld_en = 1; i_ld_addr = 32'h40; i_ld_data = 32'h4040_4040;
    i_valid = 1; i_rnw = 1; i_addr = 32'h40;
    repeat (2) @(posedge i_clk);
    #1 i_ld_en = 0;
    xfer(1'b1, 32'h40, 0, 32'h4040_4040, 1'b1);
    i_valid = 1; i_rnw = 0; i_addr = 32'h20; i_data = 32'hAAAA_AAAA;
    repeat (2) @(posedge i_clk);
    #1 i_valid = 0;
    repeat (3) @(posedge i_clk);
    #1;
    xfer(1'b1, 32'h20, 0, 32'h2020_2020, 1'b1);
    i_valid = 1; i_rnw = 0; i_addr = 32'h24; i_data = 32'hCCCC_CCCC;
    @(posedge i_clk);
    #1 i_nrst = 0;
    #1;
    chk("midwait_rst_accept", 32'(o_accept), 0);
    chk("midwait_rst_gpio", 32'(o_gpio), 0);
    chk("midwait_rst_data", o_data, 0);
    i_valid = 0;
    @(posedge i_clk);
    #1 i_nrst = 1;
    xfer(1'b1, CNT_A, 0, LAT, 1'b1);
    xfer(1'b1, 32'h24, 0, 32'h2424_2424, 1'b1);
    xfer(1'b1, GPIO_A, 0, 0, 1'b1);
    repeat (4) @(posedge i_clk);
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/x_mem_rv32i.md
X_MEM_RV32I -- requirements
Module: x_mem_rv32i

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words of RAM; power of two, 16..4096.
REQ-002 Parameter LATENCY, default 1: wait cycles inserted before each accept; range 0..15.
REQ-003 i_clk  input  1  single clock; all state on rising edge.
REQ-004 i_nrst  input  1  reset, asynchronous, active-low.
REQ-005 i_valid  input  1  initiator request present; held high until accepted.
REQ-006 i_rnw  input  1  1 = read, 0 = write; stable while i_valid high.
REQ-007 i_addr  input  32  byte address; stable while i_valid high.
REQ-008 i_data  input  32  write data; stable while i_valid high.
REQ-009 o_accept  output  1  one-cycle pulse completing the current request.
REQ-010 o_data  output  32  read data; valid in the o_accept cycle.
REQ-011 i_ld_en  input  1  loader write strobe (program preload).
REQ-012 i_ld_addr  input  32  loader byte address.
REQ-013 i_ld_data  input  32  loader write data.
REQ-014 o_gpio  output  8  GPIO output register.

Function
REQ-015 Address map: RAM at 0 .. DEPTH*4-1, word index = addr[log2(DEPTH)+1:2], addr[1:0] ignored; GPIO at 0xFFFF_FFF0; cycle counter at 0xFFFF_FFF4; all other addresses unmapped.
REQ-016 States: IDLE, WAIT, RESP.
REQ-017 IDLE: i_valid=1 and i_ld_en=0 -> capture addr/rnw/data, load wait counter with LATENCY, go WAIT if LATENCY>0 else RESP.
REQ-018 WAIT: counter decrements each cycle; RESP entered the cycle after counter reaches 1.
REQ-019 RESP: o_accept=1 for exactly one cycle, then IDLE unconditionally.
REQ-020 Latency: request first seen in IDLE at cycle N -> o_accept at cycle N+1+LATENCY.
REQ-021 Back-to-back: i_valid high in the cycle after RESP is a new request (initiator advanced on accept); no idle gap beyond the IDLE capture cycle.
REQ-022 i_valid low in WAIT or RESP: abort to IDLE, no write, o_accept low that cycle.
REQ-023 Read: o_data registered on entry to RESP from the captured address: RAM word, {24'd0,o_gpio}, counter value, or 0 if unmapped; o_data holds its value outside RESP.
REQ-024 Write: committed at the rising edge ending the RESP cycle; RAM word or o_gpio<=data[7:0]; writes to counter or unmapped addresses discarded but still accepted.
REQ-025 Loader: i_ld_en=1 writes i_ld_data to RAM word at i_ld_addr every cycle, no accept; out-of-range ld address ignored.
REQ-026 i_ld_en=1 blocks new captures in IDLE; an in-flight request completes normally.
REQ-027 Loader and bus write to same word in same edge: loader value wins.
REQ-028 Cycle counter: 32-bit free-running, +1 per cycle, wraps 0xFFFF_FFFF -> 0.
REQ-029 Read-after-write: a read accepted after a write's RESP returns the written data.

Reset
REQ-030 i_nrst low: state IDLE, o_accept 0, o_data 0, o_gpio 0, counter 0, wait counter 0, immediately and asynchronously.
REQ-031 RAM contents not affected by reset.
REQ-032 Reset mid-transaction: request discarded, no write performed.

Verification
REQ-033 LATENCY=1: load word 0 = 0x0000_0013; i_valid=1,i_rnw=1,i_addr=0 at cycle 0 -> o_accept=1, o_data=0x0000_0013 at cycle 2.
REQ-034 Write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> read returns 0xDEADBEEF; write 0x5A to 0xFFFF_FFF0 -> o_gpio=0x5A, reading it returns 0x0000_005A.
REQ-035 LATENCY=3, continuous i_valid for 3 reads -> accepts at cycles 4, 9, 14.
REQ-036 Read 0x0001_0000 (DEPTH=256) -> o_data=0, accepted; write there -> accepted, RAM unchanged.
REQ-037 Drop i_valid in WAIT during write to 0x20 -> no accept, word 0x20 unchanged; assert i_nrst=0 mid-WAIT -> o_accept 0, o_gpio 0, state IDLE.
REQ-038 Counter read two cycles apart in sequential requests differs by the cycle distance between RESP entries; forced wrap from 0xFFFF_FFFF reads 0.
